spi_msg_arbiter: RTL and testbench

//  Round-robin message arbiter sitting in the SYS_CLK domain behind N input_process_spi channels.

---
 rtl/spi_msg_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_spi_msg_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_msg_arbiter.sv
// Round-robin arbiter that drains complete messages from N SPI input channels
// into one valid/ready word stream framed with SOP/EOP.
module spi_msg_arbiter #(
  parameter int N_CH    = 4,
  parameter int DW      = 16,
  parameter int LW      = 8,
  parameter int GAP_CYC = 4
) (
  input  logic               SYS_CLK,
  input  logic               RST,
  input  logic [N_CH-1:0]    CH_EN,
  input  logic [N_CH-1:0]    CH_GOT_MSG,
  input  logic [N_CH*LW-1:0] CH_LEN,
  input  logic [N_CH*DW-1:0] CH_Q,
  output logic [N_CH-1:0]    CH_RD_REQ,
  output logic [DW-1:0]      OUT_DATA,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic               OUT_SOP,
  output logic               OUT_EOP,
  output logic [2:0]         OUT_CH,
  output logic [N_CH-1:0]    ERR,
  input  logic [N_CH-1:0]    ERR_CLR,
  output logic               BUSY,
  output logic [15:0]        MSG_CNT
);

  localparam int CW = 3;
  localparam int GW = (GAP_CYC < 1) ? 1 : $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_CAPT = 3'd2,
    S_SEND = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [CW-1:0]     last_grant_q, last_grant_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [N_CH-1:0]   rd_req_q, rd_req_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic [CW-1:0]     out_ch_q, out_ch_d;
  logic [N_CH-1:0]   err_q, err_d;
  logic              busy_q, busy_d;
  logic [15:0]       msg_cnt_q, msg_cnt_d;

  logic [N_CH-1:0]   elig_s;
  logic              found_s;
  logic [CW-1:0]     grant_s;
  logic [LW-1:0]     grant_len_s;
  logic [DW-1:0]     q_sel_s;
  int                dist_s;
  int                best_dist_s;

  // One-hot read strobe for a channel index.
  function automatic logic [N_CH-1:0] ch_onehot(input logic [CW-1:0] ch);
    ch_onehot = {{(N_CH-1){1'b0}}, 1'b1} << ch;
  endfunction

  assign elig_s      = CH_GOT_MSG & CH_EN & ~err_q;
  assign grant_len_s = CH_LEN[int'(grant_s)*LW +: LW];
  assign q_sel_s     = CH_Q[int'(ch_q)*DW +: DW];

  // Round-robin pick: smallest distance from last_grant+1 among eligible channels.
  always_comb begin
    found_s     = 1'b0;
    grant_s     = '0;
    dist_s      = 0;
    best_dist_s = N_CH;
    for (int i = 0; i < N_CH; i++) begin
      dist_s = (i + N_CH - 1 - int'(last_grant_q)) % N_CH;
      if (elig_s[i] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        grant_s     = CW'(i);
        found_s     = 1'b1;
      end else begin
        best_dist_s = best_dist_s;
      end
    end
  end

  // Next-state and registered-output logic for the message transfer FSM.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    rd_req_d     = '0;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    out_ch_d     = out_ch_q;
    err_d        = err_q & ~ERR_CLR;
    msg_cnt_d    = msg_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          ch_d         = grant_s;
          len_d        = grant_len_s;
          last_grant_d = grant_s;
          out_ch_d     = grant_s;
          if (grant_len_s < LW'(2)) begin
            // Too short to hold prefix + command: flag it and leave the FIFO untouched.
            err_d   = err_d | ch_onehot(grant_s);
            state_d = S_IDLE;
          end else begin
            cnt_d    = '0;
            rd_req_d = ch_onehot(grant_s);
            state_d  = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        out_data_d  = q_sel_s;
        out_valid_d = 1'b1;
        out_sop_d   = (cnt_q == LW'(0));
        out_eop_d   = (cnt_q == (len_q - LW'(1)));
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
          if (out_eop_q) begin
            msg_cnt_d = msg_cnt_q + 16'd1;
            gap_d     = GW'(GAP_CYC);
            state_d   = S_GAP;
          end else begin
            cnt_d    = cnt_q + LW'(1);
            rd_req_d = ch_onehot(ch_q);
            state_d  = S_READ;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(0)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      last_grant_q <= CW'(N_CH - 1);
      len_q        <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      rd_req_q     <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_ch_q     <= '0;
      err_q        <= '0;
      busy_q       <= 1'b0;
      msg_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      rd_req_q     <= rd_req_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_ch_q     <= out_ch_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      msg_cnt_q    <= msg_cnt_d;
    end
  end

  assign CH_RD_REQ = rd_req_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_SOP   = out_sop_q;
  assign OUT_EOP   = out_eop_q;
  assign OUT_CH    = out_ch_q;
  assign ERR       = err_q;
  assign BUSY      = busy_q;
  assign MSG_CNT   = msg_cnt_q;

endmodule

// File: tb/tb_spi_msg_arbiter.sv
// Directed bench for spi_msg_arbiter with behavioural per-channel FIFO models.
module tb_spi_msg_arbiter;

  localparam int N_CH = 4;
  localparam int DW   = 16;
  localparam int LW   = 8;

  logic               SYS_CLK = 1'b0;
  logic               RST;
  logic [N_CH-1:0]    CH_EN;
  logic [N_CH-1:0]    CH_GOT_MSG;
  logic [N_CH*LW-1:0] CH_LEN;
  logic [N_CH*DW-1:0] CH_Q;
  logic [N_CH-1:0]    CH_RD_REQ;
  logic [DW-1:0]      OUT_DATA;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic               OUT_SOP;
  logic               OUT_EOP;
  logic [2:0]         OUT_CH;
  logic [N_CH-1:0]    ERR;
  logic [N_CH-1:0]    ERR_CLR;
  logic               BUSY;
  logic [15:0]        MSG_CNT;

  spi_msg_arbiter #(.N_CH(N_CH), .DW(DW), .LW(LW), .GAP_CYC(4)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .CH_EN(CH_EN), .CH_GOT_MSG(CH_GOT_MSG),
    .CH_LEN(CH_LEN), .CH_Q(CH_Q), .CH_RD_REQ(CH_RD_REQ), .OUT_DATA(OUT_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_SOP(OUT_SOP),
    .OUT_EOP(OUT_EOP), .OUT_CH(OUT_CH), .ERR(ERR), .ERR_CLR(ERR_CLR),
    .BUSY(BUSY), .MSG_CNT(MSG_CNT)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // Upstream FIFO model: word memory plus a length FIFO per channel.
  logic [DW-1:0] mem  [N_CH][64];
  logic [LW-1:0] lmem [N_CH][16];
  int            wp   [N_CH];
  int            lwp  [N_CH];
  int            rp   [N_CH];
  int            lrp  [N_CH];
  int            taken[N_CH];
  logic [DW-1:0] q_r  [N_CH];
  int            underflow = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic [2:0]    ch;
  } xfer_t;

  xfer_t xfer_q[$];
  int    rd_cnt[N_CH];
  int    onehot_viol = 0;
  int    stall_viol  = 0;
  logic  prev_stall  = 1'b0;
  logic [DW-1:0] prev_data;
  logic  prev_sop, prev_eop;
  logic  tog_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO outputs seen by the DUT.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      CH_GOT_MSG[i]        = (lrp[i] != lwp[i]);
      CH_LEN[i*LW +: LW]   = lmem[i][lrp[i] % 16];
      CH_Q[i*DW +: DW]     = q_r[i];
    end
  end

  // FIFO read side: one-cycle read latency, length entry pops with the last word.
  always @(posedge SYS_CLK) begin
    for (int i = 0; i < N_CH; i++) begin
      if (RST) begin
        rp[i]    <= wp[i];
        lrp[i]   <= lwp[i];
        taken[i] <= 0;
        q_r[i]   <= '0;
      end else if (CH_RD_REQ[i]) begin
        if (rp[i] == wp[i]) underflow <= underflow + 1;
        q_r[i] <= mem[i][rp[i] % 64];
        rp[i]  <= rp[i] + 1;
        if (taken[i] + 1 == int'(lmem[i][lrp[i] % 16])) begin
          taken[i] <= 0;
          lrp[i]   <= lrp[i] + 1;
        end else begin
          taken[i] <= taken[i] + 1;
        end
      end
    end
  end

  // Output monitor on the falling edge: handshakes, read strobes, stall stability.
  always @(negedge SYS_CLK) begin
    if (!RST) begin
      if (OUT_VALID && OUT_READY)
        xfer_q.push_back('{d: OUT_DATA, sop: OUT_SOP, eop: OUT_EOP, ch: OUT_CH});
      for (int i = 0; i < N_CH; i++)
        if (CH_RD_REQ[i]) rd_cnt[i] <= rd_cnt[i] + 1;
      if ($countones(CH_RD_REQ) > 1) onehot_viol <= onehot_viol + 1;
      if (prev_stall && (!OUT_VALID || OUT_DATA != prev_data || OUT_SOP != prev_sop ||
                         OUT_EOP != prev_eop || CH_RD_REQ != '0))
        stall_viol <= stall_viol + 1;
    end
    prev_stall <= OUT_VALID && !OUT_READY && !RST;
    prev_data  <= OUT_DATA;
    prev_sop   <= OUT_SOP;
    prev_eop   <= OUT_EOP;
  end

  // READY toggler for the back-pressure test.
  always @(posedge SYS_CLK) begin
    #2;
    if (tog_en) OUT_READY = ~OUT_READY;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic push_msg(input int ch, input int len, input logic [DW-1:0] base);
    for (int k = 0; k < len; k++) begin
      mem[ch][wp[ch] % 64] = base + DW'(k);
      wp[ch] = wp[ch] + 1;
    end
    lmem[ch][lwp[ch] % 16] = LW'(len);
    lwp[ch] = lwp[ch] + 1;
  endtask

  task automatic unpush_msg(input int ch, input int len);
    wp[ch]  = wp[ch] - len;
    lwp[ch] = lwp[ch] - 1;
  endtask

  task automatic wait_xfers(input string tag, input int n, input int budget);
    int b;
    b = 0;
    while (xfer_q.size() < n && b < budget) begin
      tick();
      b++;
    end
    check({tag, "_arrive"}, 32'(xfer_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int b;
    b = 0;
    while (BUSY && b < 200) begin
      tick();
      b++;
    end
    check({tag, "_idle"}, 32'(BUSY), 32'd0);
  endtask

  task automatic expect_msg(input string tag, input int ch, input int len, input logic [DW-1:0] base);
    xfer_t x;
    wait_xfers(tag, len, 60 * len);
    for (int k = 0; k < len; k++) begin
      x = (xfer_q.size() > 0) ? xfer_q.pop_front() : '0;
      check({tag, "_data"}, 32'(x.d), 32'(base + DW'(k)));
      check({tag, "_sop"}, 32'(x.sop), 32'(k == 0));
      check({tag, "_eop"}, 32'(x.eop), 32'(k == len - 1));
      check({tag, "_ch"}, 32'(x.ch), 32'(ch));
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    xfer_q.delete();
  endtask

  initial begin
    int snap;
    int b;
    for (int i = 0; i < N_CH; i++) begin
      wp[i] = 0; lwp[i] = 0; rd_cnt[i] = 0;
      for (int j = 0; j < 16; j++) lmem[i][j] = '0;
    end
    RST = 1'b1; CH_EN = '1; OUT_READY = 1'b1; ERR_CLR = '0;
    tick();
    tick();
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_rdreq", 32'(CH_RD_REQ), 32'd0);
    check("rst_msgcnt", 32'(MSG_CNT), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    RST = 1'b0;
    tick();

    // 1) ch1 alone, three words.
    snap = rd_cnt[1];
    push_msg(1, 3, 16'hA000);
    expect_msg("t1", 1, 3, 16'hA000);
    wait_idle("t1");
    check("t1_rdreq", 32'(rd_cnt[1] - snap), 32'd3);
    check("t1_outch", 32'(OUT_CH), 32'd1);
    check("t1_msgcnt", 32'(MSG_CNT), 32'd1);

    // 2) all channels pending: order 0,1,2,3 then ch0 again.
    do_reset();
    push_msg(0, 2, 16'hB000);
    push_msg(1, 2, 16'hB100);
    push_msg(2, 2, 16'hB200);
    push_msg(3, 2, 16'hB300);
    push_msg(0, 2, 16'hB010);
    expect_msg("t2_c0", 0, 2, 16'hB000);
    expect_msg("t2_c1", 1, 2, 16'hB100);
    expect_msg("t2_c2", 2, 2, 16'hB200);
    expect_msg("t2_c3", 3, 2, 16'hB300);
    expect_msg("t2_c0b", 0, 2, 16'hB010);
    wait_idle("t2");
    check("t2_msgcnt", 32'(MSG_CNT), 32'd5);

    // 3) ch2 with READY toggling every cycle.
    snap = rd_cnt[2];
    push_msg(2, 4, 16'hC200);
    tog_en = 1'b1;
    expect_msg("t3", 2, 4, 16'hC200);
    tog_en = 1'b0;
    OUT_READY = 1'b1;
    wait_idle("t3");
    check("t3_rdreq", 32'(rd_cnt[2] - snap), 32'd4);
    check("t3_stall", 32'(stall_viol), 32'd0);

    // 4) bad length on ch3, skip, then clear and serve.
    snap = rd_cnt[3];
    push_msg(3, 1, 16'hD300);
    for (int k = 0; k < 10; k++) tick();
    check("t4_err", 32'(ERR), 32'h8);
    check("t4_rdreq0", 32'(rd_cnt[3] - snap), 32'd0);
    check("t4_busy", 32'(BUSY), 32'd0);
    check("t4_outch", 32'(OUT_CH), 32'd3);
    push_msg(2, 2, 16'hD200);
    expect_msg("t4_c2", 2, 2, 16'hD200);
    wait_idle("t4a");
    check("t4_err_hold", 32'(ERR), 32'h8);
    unpush_msg(3, 1);
    push_msg(3, 2, 16'hD310);
    ERR_CLR = 4'h8;
    tick();
    ERR_CLR = 4'h0;
    check("t4_errclr", 32'(ERR), 32'h0);
    expect_msg("t4_c3", 3, 2, 16'hD310);
    wait_idle("t4b");
    check("t4_rdreq2", 32'(rd_cnt[3] - snap), 32'd2);
    check("t4_msgcnt", 32'(MSG_CNT), 32'd8);

    // 5) reset while word 2 of 5 is presented.
    push_msg(1, 5, 16'hE100);
    wait_xfers("t5_w1", 1, 60);
    b = 0;
    while (!OUT_VALID && b < 20) begin
      tick();
      b++;
    end
    check("t5_w2_valid", 32'(OUT_VALID), 32'd1);
    RST = 1'b1;
    tick();
    check("t5_valid", 32'(OUT_VALID), 32'd0);
    check("t5_data", 32'(OUT_DATA), 32'd0);
    check("t5_sopeop", 32'({OUT_SOP, OUT_EOP}), 32'd0);
    check("t5_rdreq", 32'(CH_RD_REQ), 32'd0);
    check("t5_busy", 32'(BUSY), 32'd0);
    check("t5_outch", 32'(OUT_CH), 32'd0);
    check("t5_msgcnt", 32'(MSG_CNT), 32'd0);
    RST = 1'b0;
    xfer_q.delete();
    tick();
    push_msg(2, 2, 16'hE200);
    push_msg(0, 2, 16'hE000);
    expect_msg("t5_c0", 0, 2, 16'hE000);
    expect_msg("t5_c2", 2, 2, 16'hE200);
    wait_idle("t5");
    check("t5_msgcnt2", 32'(MSG_CNT), 32'd2);

    // 6) CH_EN[0] dropped mid-message.
    snap = rd_cnt[0];
    push_msg(0, 3, 16'hF000);
    push_msg(0, 3, 16'hF010);
    wait_xfers("t6_w1", 1, 60);
    CH_EN = 4'hE;
    expect_msg("t6_m1", 0, 3, 16'hF000);
    for (int k = 0; k < 40; k++) tick();
    check("t6_noxfer", 32'(xfer_q.size()), 32'd0);
    check("t6_rdreq1", 32'(rd_cnt[0] - snap), 32'd3);
    check("t6_busy", 32'(BUSY), 32'd0);
    CH_EN = 4'hF;
    expect_msg("t6_m2", 0, 3, 16'hF010);
    wait_idle("t6");
    check("t6_rdreq2", 32'(rd_cnt[0] - snap), 32'd6);
    check("t6_msgcnt", 32'(MSG_CNT), 32'd4);

    check("onehot", 32'(onehot_viol), 32'd0);
    check("underflow", 32'(underflow), 32'd0);
    check("stall_final", 32'(stall_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
